// File: rtl/execute_pipe_if.sv
// Execute-stage handshake bundle.
// Decode side drives master; the stage itself uses slave.
interface execute_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [1:0]       ir_src;
    logic [WIDTH-1:0] pc_in;
    logic [31:0]      ir_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] st_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] y_out;
    logic [WIDTH-1:0] st_out;
    logic [31:0]      ir_out;
    logic             illegal_op;

    modport master (
        output in_valid, flush, ir_src, pc_in, ir_in,
        output a_in, b_in, st_in, out_ready,
        input  in_ready, out_valid, pc_out, y_out,
        input  st_out, ir_out, illegal_op
    );

    modport slave (
        input  in_valid, flush, ir_src, pc_in, ir_in,
        input  a_in, b_in, st_in, out_ready,
        output in_ready, out_valid, pc_out, y_out,
        output st_out, ir_out, illegal_op
    );
endinterface

// File: rtl/execute_pipe.sv
// Beta execute stage: ALU, multi-cycle MUL, flush and
// illegal-opcode trapping, registered toward mem.
module execute_pipe #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2,
    parameter bit EN_MUL     = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    execute_pipe_if.slave bus
);
    localparam logic [31:0] INST_NOP        = 32'h83FF_F800;
    localparam logic [31:0] INST_BNE_EXCEPT = 32'h77DF_0000;
    localparam logic [1:0]  IR_SRC_DATA     = 2'd0;
    localparam logic [1:0]  IR_SRC_EXCEPT   = 2'd2;
    localparam int SH = $clog2(WIDTH);
    localparam int CW = (MUL_STAGES > 2) ? $clog2(MUL_STAGES - 1) : 1;
    localparam int CNT_INIT = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;

    typedef enum logic { S_IDLE, S_MUL } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, b_q, pc_q, st_q;
    logic [31:0]      ir_q;
    logic             out_valid_q, out_valid_d;
    logic             ill_q, ill_d;
    logic [WIDTH-1:0] pc_out_q, pc_out_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] st_out_q, st_out_d;
    logic [31:0]      ir_out_q, ir_out_d;

    logic             in_mul, out_free, accept, mul_multi;
    logic             load_single, load_mul, load;
    logic [WIDTH-1:0] sel_a, sel_b, sel_pc, sel_st;
    logic [31:0]      sel_ir;
    logic [1:0]       src;
    logic [5:0]       op;
    logic [SH-1:0]    shamt;
    logic             legal, is_mul;
    logic [WIDTH-1:0] alu_y;
    logic [31:0]      res_ir;
    logic [WIDTH-1:0] res_y;
    logic             res_ill;

    assign in_mul   = (state_q == S_MUL);
    assign out_free = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = ~in_mul & ~bus.flush & out_free;
    assign accept   = bus.in_valid & bus.in_ready;

    // While a MUL runs the latched operands feed the ALU;
    // only legal DATA MULs ever reach that state.
    assign sel_a  = in_mul ? a_q  : bus.a_in;
    assign sel_b  = in_mul ? b_q  : bus.b_in;
    assign sel_pc = in_mul ? pc_q : bus.pc_in;
    assign sel_st = in_mul ? st_q : bus.st_in;
    assign sel_ir = in_mul ? ir_q : bus.ir_in;
    assign src    = in_mul ? IR_SRC_DATA : bus.ir_src;
    assign op     = sel_ir[31:26];
    assign shamt  = sel_b[SH-1:0];

    // Opcode decode and ALU; 11xxxx mirrors 10xxxx
    always_comb begin
        alu_y  = '0;
        legal  = 1'b1;
        is_mul = 1'b0;
        if (op[5]) begin
            unique case (op[3:0])
                4'h0: alu_y = sel_a + sel_b;
                4'h1: alu_y = sel_a - sel_b;
                4'h2: begin
                    is_mul = 1'b1;
                    legal  = EN_MUL;
                    alu_y  = sel_a * sel_b;
                end
                4'h4: alu_y = {{(WIDTH-1){1'b0}}, sel_a == sel_b};
                4'h5: alu_y = {{(WIDTH-1){1'b0}},
                               $signed(sel_a) < $signed(sel_b)};
                4'h6: alu_y = {{(WIDTH-1){1'b0}},
                               $signed(sel_a) <= $signed(sel_b)};
                4'h8: alu_y = sel_a & sel_b;
                4'h9: alu_y = sel_a | sel_b;
                4'hA: alu_y = sel_a ^ sel_b;
                4'hB: alu_y = ~(sel_a ^ sel_b);
                4'hC: alu_y = sel_a << shamt;
                4'hD: alu_y = sel_a >> shamt;
                4'hE: alu_y = $signed(sel_a) >>> shamt;
                default: legal = 1'b0;
            endcase
        end else begin
            unique case (op)
                6'h18, 6'h19:        alu_y = sel_a + sel_b;
                6'h1B, 6'h1C, 6'h1D: alu_y = sel_pc;
                6'h1F:               alu_y = sel_b;
                default:             legal = 1'b0;
            endcase
        end
    end

    // ir_src substitution and illegal-opcode trap
    always_comb begin
        res_ir  = sel_ir;
        res_y   = alu_y;
        res_ill = 1'b0;
        if (src == IR_SRC_EXCEPT) begin
            res_ir = INST_BNE_EXCEPT;
            res_y  = sel_pc;
        end else if (src != IR_SRC_DATA) begin
            res_ir = INST_NOP;
            res_y  = '0;
        end else if (!legal) begin
            res_ir  = INST_BNE_EXCEPT;
            res_y   = sel_pc;
            res_ill = 1'b1;
        end
    end

    assign mul_multi = (MUL_STAGES > 1) && (src == IR_SRC_DATA)
                       && legal && is_mul;
    assign load_single = accept & ~mul_multi;
    assign load_mul    = in_mul & (cnt_q == '0) & out_free & ~bus.flush;
    assign load        = load_single | load_mul;

    // FSM next state; the accept cycle is the first MUL cycle,
    // so the counter starts at MUL_STAGES-2
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else if (accept && mul_multi) begin
            state_d = S_MUL;
            cnt_d   = CW'(CNT_INIT);
        end else if (in_mul) begin
            if (load_mul) begin
                state_d = S_IDLE;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Output register next state; flush wins over everything
    always_comb begin
        out_valid_d = out_valid_q;
        ill_d       = ill_q;
        pc_out_d    = pc_out_q;
        y_d         = y_q;
        st_out_d    = st_out_q;
        ir_out_d    = ir_out_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
            ill_d       = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            ill_d       = res_ill;
            pc_out_d    = sel_pc;
            y_d         = res_y;
            st_out_d    = sel_st;
            ir_out_d    = res_ir;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
            ill_d       = 1'b0;
        end
    end

    // State, operand latches and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            pc_q        <= '0;
            st_q        <= '0;
            ir_q        <= INST_NOP;
            out_valid_q <= 1'b0;
            ill_q       <= 1'b0;
            pc_out_q    <= '0;
            y_q         <= '0;
            st_out_q    <= '0;
            ir_out_q    <= INST_NOP;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (accept) begin
                a_q  <= bus.a_in;
                b_q  <= bus.b_in;
                pc_q <= bus.pc_in;
                st_q <= bus.st_in;
                ir_q <= bus.ir_in;
            end
            out_valid_q <= out_valid_d;
            ill_q       <= ill_d;
            pc_out_q    <= pc_out_d;
            y_q         <= y_d;
            st_out_q    <= st_out_d;
            ir_out_q    <= ir_out_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.illegal_op = ill_q;
    assign bus.pc_out     = pc_out_q;
    assign bus.y_out      = y_q;
    assign bus.st_out     = st_out_q;
    assign bus.ir_out     = ir_out_q;
endmodule
